// File: rtl/inv_add_round_key_stage.sv
// Registered AddRoundKey stage for the iterative AES-128 inverse cipher, ahead of InvMixColumns.
// Optional macro INV_ARK_SKID_EN adds a 2-entry skid buffer so in_ready does not depend on out_ready.
module inv_add_round_key_stage #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_wr_en,
    input  logic [3:0]   key_wr_idx,
    input  logic [127:0] key_wr_data,
    output logic         key_loaded,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_first,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic [3:0]   out_round,
    output logic         out_mix_en,
    output logic         out_last,
    output logic         err_seq
);
    localparam logic [3:0] NR_IDX  = 4'(NR);
    localparam logic [3:0] NR_NEXT = 4'(NR - 1);

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic [127:0] state;
        logic [3:0]   round;
        logic         mix_en;
        logic         last;
    } ark_res_t;

    state_t       state;
    logic [3:0]   round_q;
    logic [NR:0]  key_mask;
    logic [127:0] key_mem [0:NR];
    ark_res_t     out_q;
    ark_res_t     res;

    logic         accept;
    logic         produce;
    logic         seq_err;
    logic         busy;
    logic         wr_ok;
    logic [3:0]   sel_idx;
    logic [NR:0]  wr_onehot;

    assign accept  = in_valid & in_ready;
    // A non-first state only has a key to use while a block is running.
    assign produce = accept & (in_first | (state == RUN));
    assign seq_err = accept & (in_first ? (state == RUN) : (state == IDLE));
    assign sel_idx = (state == RUN && !in_first) ? round_q : NR_IDX;

    always_comb begin
        res.state  = in_state ^ key_mem[sel_idx];
        res.round  = sel_idx;
        res.mix_en = (sel_idx != 4'd0) && (sel_idx != NR_IDX);
        res.last   = (sel_idx == 4'd0);
    end

    assign out_state  = out_q.state;
    assign out_round  = out_q.round;
    assign out_mix_en = out_q.mix_en;
    assign out_last   = out_q.last;

    // ---------------- key bank ----------------
    assign wr_ok     = key_wr_en & (key_wr_idx <= NR_IDX) & ~busy;
    assign wr_onehot = wr_ok ? ((NR + 1)'(1) << key_wr_idx) : '0;

    always_ff @(posedge clk) begin
        if (wr_ok)
            key_mem[key_wr_idx] <= key_wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_mask   <= '0;
            key_loaded <= 1'b0;
        end else begin
            key_mask   <= key_mask | wr_onehot;
            key_loaded <= &(key_mask | wr_onehot);
        end
    end

    // ---------------- round sequencer ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            round_q <= NR_IDX;
            err_seq <= 1'b0;
        end else begin
            err_seq <= err_seq | seq_err;
            if (accept) begin
                if (in_first) begin
                    state   <= RUN;
                    round_q <= NR_NEXT;
                end else if (state == RUN) begin
                    if (round_q == 4'd0) begin
                        state   <= IDLE;
                        round_q <= NR_IDX;
                    end else begin
                        round_q <= 4'(round_q - 4'd1);
                    end
                end
            end
        end
    end

`ifdef INV_ARK_SKID_EN
    // ---------------- skid buffer + output register ----------------
    ark_res_t   skid_q [0:1];
    logic [1:0] skid_cnt;
    logic       skid_rd;
    logic       skid_wr;
    logic       out_load;
    logic       skid_pop;
    logic       skid_push;

    assign busy      = (state != IDLE) | out_valid | (skid_cnt != 2'd0);
    assign in_ready  = key_loaded & ~key_wr_en & (skid_cnt != 2'd2);
    assign out_load  = ~out_valid | out_ready;
    assign skid_pop  = out_load & (skid_cnt != 2'd0);
    // Results bypass the skid only when it is empty, so ordering is kept.
    assign skid_push = produce & ~(out_load & (skid_cnt == 2'd0));

    always_ff @(posedge clk) begin
        if (skid_push)
            skid_q[skid_wr] <= res;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            skid_cnt <= 2'd0;
            skid_rd  <= 1'b0;
            skid_wr  <= 1'b0;
        end else begin
            if (skid_push)
                skid_wr <= ~skid_wr;
            if (skid_pop)
                skid_rd <= ~skid_rd;
            case ({skid_push, skid_pop})
                2'b10:   skid_cnt <= 2'(skid_cnt + 2'd1);
                2'b01:   skid_cnt <= 2'(skid_cnt - 2'd1);
                default: skid_cnt <= skid_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_q     <= '0;
        end else if (out_load) begin
            if (skid_pop) begin
                out_valid <= 1'b1;
                out_q     <= skid_q[skid_rd];
            end else if (produce) begin
                out_valid <= 1'b1;
                out_q     <= res;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end
`else
    // ---------------- single output register ----------------
    assign busy     = (state != IDLE) | out_valid;
    assign in_ready = key_loaded & ~key_wr_en & (~out_valid | out_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_q     <= '0;
        end else if (produce) begin
            out_valid <= 1'b1;
            out_q     <= res;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_inv_add_round_key_stage.sv
// Directed/random bench for inv_add_round_key_stage against a round-sequence reference model.
module tb_inv_add_round_key_stage;
    localparam int NR = 10;
    localparam logic [127:0] FIPS_K10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] FIPS_IN  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] FIPS_OUT = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
    localparam logic [127:0] K0       = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIN_IN   = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [127:0] FIN_OUT  = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_wr_en = 1'b0;
    logic [3:0]   key_wr_idx = '0;
    logic [127:0] key_wr_data = '0;
    logic         key_loaded;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         in_first = 1'b0;
    logic [127:0] in_state = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] out_state;
    logic [3:0]   out_round;
    logic         out_mix_en;
    logic         out_last;
    logic         err_seq;

    int checks = 0;
    int errors = 0;
    logic [127:0] keys [0:NR];
    int m_next = NR;

    inv_add_round_key_stage #(.NR(NR)) dut (
        .clk(clk), .rst_n(rst_n),
        .key_wr_en(key_wr_en), .key_wr_idx(key_wr_idx), .key_wr_data(key_wr_data),
        .key_loaded(key_loaded),
        .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first), .in_state(in_state),
        .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
        .out_round(out_round), .out_mix_en(out_mix_en), .out_last(out_last),
        .err_seq(err_seq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkr(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic write_key(input int idx, input logic [127:0] data);
        key_wr_en   = 1'b1;
        key_wr_idx  = 4'(idx);
        key_wr_data = data;
        tick();
        key_wr_en = 1'b0;
        if (idx <= NR)
            keys[idx] = data;
    endtask

    task automatic load_keys();
        for (int i = 0; i <= NR; i++)
            write_key(i, (i == 0) ? K0 : rnd128());
    endtask

    // Present one state and hold it until the stage takes it.
    task automatic xfer(input logic first, input logic [127:0] st);
        int n;
        in_valid = 1'b1;
        in_first = first;
        in_state = st;
        #1;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        chkb("accept_timeout", n < 20, 1'b1);
        tick();
        in_valid = 1'b0;
    endtask

    // Reference: a block consumes keys NR, NR-1, ..., 0; a first state restarts at NR.
    task automatic expect_out(input logic first, input logic [127:0] st);
        int r;
        if (first) begin
            r = NR;
            m_next = NR - 1;
        end else begin
            r = m_next;
            m_next = (r == 0) ? NR : r - 1;
        end
        chkb("out_valid", out_valid, 1'b1);
        chkw("out_state", out_state, st ^ keys[r]);
        chkr("out_round", out_round, 4'(r));
        chkb("out_mix_en", out_mix_en, (r >= 1) && (r <= NR - 1));
        chkb("out_last", out_last, r == 0);
    endtask

    task automatic send(input logic first, input logic [127:0] st);
        xfer(first, st);
        expect_out(first, st);
    endtask

    initial begin
        logic [127:0] s;
        logic [127:0] held;

        // reset state
        tick();
        tick();
        chkb("rst_out_valid", out_valid, 1'b0);
        chkw("rst_out_state", out_state, '0);
        chkr("rst_out_round", out_round, 4'd0);
        chkb("rst_key_loaded", key_loaded, 1'b0);
        chkb("rst_err_seq", err_seq, 1'b0);
        chkb("rst_in_ready", in_ready, 1'b0);
        rst_n = 1'b1;
        tick();

        // key load gating
        for (int i = 0; i < NR; i++)
            write_key(i, (i == 0) ? K0 : rnd128());
        #1;
        chkb("partial_key_loaded", key_loaded, 1'b0);
        chkb("partial_in_ready", in_ready, 1'b0);
        write_key(12, rnd128());
        tick();
        chkb("idx12_key_loaded", key_loaded, 1'b0);
        write_key(NR, FIPS_K10);
        chkb("full_key_loaded", key_loaded, 1'b1);
        #1;
        chkb("loaded_in_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        in_first = 1'b1;
        key_wr_en = 1'b1;
        key_wr_idx = 4'd5;
        #1;
        chkb("wr_priority_in_ready", in_ready, 1'b0);
        key_wr_en = 1'b0;
        in_valid = 1'b0;
        #1;

        // FIPS-197 C.1 block: initial ARK, nine middle rounds, final ARK
        send(1'b1, FIPS_IN);
        chkw("fips_init_state", out_state, FIPS_OUT);
        for (int r = NR - 1; r >= 1; r--)
            send(1'b0, rnd128());
        send(1'b0, FIN_IN);
        chkw("fips_final_state", out_state, FIN_OUT);
        chkb("no_err_after_block", err_seq, 1'b0);
        tick();
        chkb("drained_out_valid", out_valid, 1'b0);

        // backpressure
        out_ready = 1'b0;
        s = rnd128();
        send(1'b1, s);
        held = out_state;
        in_valid = 1'b1;
        in_first = 1'b0;
        in_state = rnd128();
        for (int c = 0; c < 5; c++) begin
            #1;
            chkb("bp_in_ready", in_ready, 1'b0);
            tick();
            chkb("bp_out_valid", out_valid, 1'b1);
            chkw("bp_out_stable", out_state, held);
        end
        out_ready = 1'b1;
        #1;
        chkb("release_in_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        expect_out(1'b0, in_state);
        for (int r = NR - 2; r >= 0; r--)
            send(1'b0, rnd128());
        tick();
        chkb("bp_drained", out_valid, 1'b0);

        // non-first state while idle is dropped and flagged
        xfer(1'b0, rnd128());
        chkb("idle_nonfirst_no_out", out_valid, 1'b0);
        chkb("idle_nonfirst_err", err_seq, 1'b1);

        // first state mid-block restarts at round NR
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        load_keys();
        send(1'b1, rnd128());
        for (int r = NR - 1; r >= 5; r--)
            send(1'b0, rnd128());
        chkb("pre_restart_err", err_seq, 1'b0);
        send(1'b1, rnd128());
        chkb("restart_err", err_seq, 1'b1);
        chkr("restart_round", out_round, 4'(NR));

        // reset mid-block at round 5
        for (int r = NR - 1; r >= 5; r--)
            send(1'b0, rnd128());
        in_valid = 1'b1;
        in_first = 1'b0;
        in_state = rnd128();
        rst_n = 1'b0;
        tick();
        in_valid = 1'b0;
        chkb("midrst_out_valid", out_valid, 1'b0);
        chkb("midrst_err_seq", err_seq, 1'b0);
        chkb("midrst_key_loaded", key_loaded, 1'b0);
        chkr("midrst_out_round", out_round, 4'd0);
        rst_n = 1'b1;
        tick();
        load_keys();
        send(1'b1, rnd128());
        for (int r = NR - 1; r >= 0; r--)
            send(1'b0, rnd128());
        chkb("post_rst_err", err_seq, 1'b0);
        tick();
        chkb("post_rst_drained", out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
